audio_buffer_ctrl: RTL and testbench

//  Ping-pong sample buffer and scheduler between the SD-card sector reader and the
//  I2S DAC serializer. Packs little-endian WAV bytes into 16-bit samples and requests
//  512-byte sectors whenever a half-buffer is free. Delivers one sample per

---
 rtl/audio_pkg.sv | 22 ++
 rtl/sample_dpram.sv | 47 ++++
 rtl/audio_buffer_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_audio_buffer_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// ----------------------------------------------------------------------------
// audio_pkg
// Shared constants for the audio ping-pong buffer: sector size, sample width
// and the address widths derived from them. Also holds a small helper that
// turns the two half-buffer full flags into a fill level.
// ----------------------------------------------------------------------------
package audio_pkg;

    localparam int SECTOR_BYTES     = 512;
    localparam int SAMPLE_W         = 16;
    localparam int BYTES_PER_SAMPLE = SAMPLE_W / 8;
    localparam int HALF_WORDS       = SECTOR_BYTES / BYTES_PER_SAMPLE;
    localparam int HALF_AW          = $clog2(SECTOR_BYTES / 2);
    localparam int BYTE_CW          = $clog2(SECTOR_BYTES);
    localparam int RAM_AW           = HALF_AW + 1;

    // Number of full halves (0..2) from the per-half full flags.
    function automatic logic [1:0] count_full(input logic [1:0] full);
        return {1'b0, full[0]} + {1'b0, full[1]};
    endfunction

endpackage

// File: rtl/sample_dpram.sv
// ----------------------------------------------------------------------------
// sample_dpram
// Simple dual-port sample RAM: one write port, one synchronous read port with
// a single cycle of read latency. No reset on the array so it maps onto block
// RAM.
// Ports:
//   clk      in   clock
//   i_we     in   write enable
//   i_waddr  in   write address
//   i_wdata  in   write data
//   i_re     in   read enable
//   i_raddr  in   read address
//   o_rdata  out  read data, valid the cycle after i_re
// ----------------------------------------------------------------------------
module sample_dpram #(
    parameter int AW = 9,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [0:(2**AW)-1];
    logic [DW-1:0] r_rdata;

    // Write port.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/audio_buffer_ctrl.sv
// ----------------------------------------------------------------------------
// audio_buffer_ctrl
// Ping-pong sample buffer between the SD sector reader and the I2S serializer.
// Little-endian WAV bytes are packed into 16-bit samples and written into the
// current write half; a sector is requested whenever that half is empty. Each
// serializer load pulse returns one sample two clock edges later (RAM read +
// output register), or silence with a sticky underrun flag when starved.
// Ports:
//   clock_50M   in   system clock
//   rst_n       in   asynchronous reset, active low
//   play_en     in   level; low stops playback and flushes the buffer
//   byte_data   in   sector byte from SD reader
//   byte_valid  in   byte_data qualifier
//   sector_req  out  write half empty, reader may send one sector
//   sample_req  in   one-cycle load pulse from serializer
//   wav_data    out  sample to serializer, held between loads
//   buf_level   out  number of full halves
//   underrun    out  sticky: load pulse with no full half
//   overflow    out  sticky: byte offered while write half full
// ----------------------------------------------------------------------------
module audio_buffer_ctrl
    import audio_pkg::*;
(
    input  logic                clock_50M,
    input  logic                rst_n,
    input  logic                play_en,
    input  logic [7:0]          byte_data,
    input  logic                byte_valid,
    output logic                sector_req,
    input  logic                sample_req,
    output logic [SAMPLE_W-1:0] wav_data,
    output logic [1:0]          buf_level,
    output logic                underrun,
    output logic                overflow
);

    localparam logic [BYTE_CW-1:0] BYTE_CNT_LAST = BYTE_CW'(SECTOR_BYTES - 1);
    localparam logic [HALF_AW-1:0] RD_IDX_LAST   = HALF_AW'(HALF_WORDS - 1);

    logic                r_play_d;
    logic [1:0]          r_full;
    logic                r_wr_half;
    logic                r_rd_half;
    logic [BYTE_CW-1:0]  r_byte_cnt;
    logic [HALF_AW-1:0]  r_rd_idx;
    logic [7:0]          r_low_byte;
    logic                r_rd_pend;
    logic                r_rd_hit_d;
    logic                r_sector_req;
    logic [SAMPLE_W-1:0] r_wav_data;
    logic [1:0]          r_buf_level;
    logic                r_underrun;
    logic                r_overflow;

    logic                w_wr_accept;
    logic                w_wr_last;
    logic                w_rd_hit;
    logic                w_rd_last;
    logic [1:0]          w_full_set;
    logic [1:0]          w_full_clr;
    logic [1:0]          w_full_nxt;
    logic                w_ram_we;
    logic [RAM_AW-1:0]   w_ram_waddr;
    logic [SAMPLE_W-1:0] w_ram_wdata;
    logic [RAM_AW-1:0]   w_ram_raddr;
    logic [SAMPLE_W-1:0] w_ram_rdata;

    // Accept/complete decisions for both sides and the next full-flag state.
    // A write completion and a read drain always touch different halves, so
    // set and clear masks never collide.
    always_comb begin
        w_wr_accept = byte_valid & play_en & ~r_full[r_wr_half];
        w_wr_last   = w_wr_accept & (r_byte_cnt == BYTE_CNT_LAST);
        w_rd_hit    = sample_req & play_en & r_full[r_rd_half];
        w_rd_last   = w_rd_hit & (r_rd_idx == RD_IDX_LAST);
        w_full_set  = w_wr_last ? (r_wr_half ? 2'b10 : 2'b01) : 2'b00;
        w_full_clr  = w_rd_last ? (r_rd_half ? 2'b10 : 2'b01) : 2'b00;
        w_full_nxt  = (r_full | w_full_set) & ~w_full_clr;
        // Odd byte completes a sample: {high, latched low}.
        w_ram_we    = w_wr_accept & r_byte_cnt[0];
        w_ram_waddr = {r_wr_half, r_byte_cnt[BYTE_CW-1:1]};
        w_ram_wdata = {byte_data, r_low_byte};
        w_ram_raddr = {r_rd_half, r_rd_idx};
    end

    sample_dpram #(
        .AW (RAM_AW),
        .DW (SAMPLE_W)
    ) u_ram (
        .clk     (clock_50M),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata),
        .i_re    (w_rd_hit),
        .i_raddr (w_ram_raddr),
        .o_rdata (w_ram_rdata)
    );

    // Pointers, full flags, read pipeline and registered outputs; play_en low
    // holds the whole datapath in its flushed state.
    always_ff @(posedge clock_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_full       <= 2'b00;
            r_wr_half    <= 1'b0;
            r_rd_half    <= 1'b0;
            r_byte_cnt   <= '0;
            r_rd_idx     <= '0;
            r_low_byte   <= 8'h00;
            r_rd_pend    <= 1'b0;
            r_rd_hit_d   <= 1'b0;
            r_sector_req <= 1'b0;
            r_wav_data   <= '0;
            r_buf_level  <= 2'b00;
        end else begin
            r_sector_req <= play_en & ~r_full[r_wr_half];
            if (!play_en) begin
                r_full      <= 2'b00;
                r_wr_half   <= 1'b0;
                r_rd_half   <= 1'b0;
                r_byte_cnt  <= '0;
                r_rd_idx    <= '0;
                r_low_byte  <= 8'h00;
                r_rd_pend   <= 1'b0;
                r_rd_hit_d  <= 1'b0;
                r_wav_data  <= '0;
                r_buf_level <= 2'b00;
            end else begin
                r_full      <= w_full_nxt;
                r_buf_level <= count_full(w_full_nxt);
                if (w_wr_accept) begin
                    if (!r_byte_cnt[0]) begin
                        r_low_byte <= byte_data;
                    end
                    if (w_wr_last) begin
                        r_byte_cnt <= '0;
                        r_wr_half  <= ~r_wr_half;
                    end else begin
                        r_byte_cnt <= r_byte_cnt + 1'b1;
                    end
                end
                if (w_rd_hit) begin
                    if (w_rd_last) begin
                        r_rd_idx  <= '0;
                        r_rd_half <= ~r_rd_half;
                    end else begin
                        r_rd_idx <= r_rd_idx + 1'b1;
                    end
                end
                // Second stage: RAM data is ready, load output or silence.
                r_rd_pend  <= sample_req;
                r_rd_hit_d <= w_rd_hit;
                if (r_rd_pend) begin
                    r_wav_data <= r_rd_hit_d ? w_ram_rdata : '0;
                end
            end
        end
    end

    // Sticky status flags; cleared by reset or a play_en rising edge.
    always_ff @(posedge clock_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_play_d   <= 1'b0;
            r_underrun <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_play_d <= play_en;
            if (play_en && !r_play_d) begin
                r_underrun <= 1'b0;
                r_overflow <= 1'b0;
            end else begin
                if (sample_req && play_en && !r_full[r_rd_half]) begin
                    r_underrun <= 1'b1;
                end
                if (byte_valid && play_en && r_full[r_wr_half]) begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    assign sector_req = r_sector_req;
    assign wav_data   = r_wav_data;
    assign buf_level  = r_buf_level;
    assign underrun   = r_underrun;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_audio_buffer_ctrl.sv
module tb_audio_buffer_ctrl;

    logic        clock_50M = 1'b0;
    logic        rst_n;
    logic        play_en;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        sample_req;
    logic        sector_req;
    logic [15:0] wav_data;
    logic [1:0]  buf_level;
    logic        underrun;
    logic        overflow;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] model_q[$];   // samples committed to the buffer, in play order
    logic [15:0] sb_q[$];      // expected outputs awaiting the DUT
    logic [15:0] last_wav;

    audio_buffer_ctrl dut (
        .clock_50M  (clock_50M),
        .rst_n      (rst_n),
        .play_en    (play_en),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .sector_req (sector_req),
        .sample_req (sample_req),
        .wav_data   (wav_data),
        .buf_level  (buf_level),
        .underrun   (underrun),
        .overflow   (overflow)
    );

    always #10 clock_50M = ~clock_50M;

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int model_halves();
        return (model_q.size() + 255) / 256;
    endfunction

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clock_50M);
    endtask

    // Stream n bytes (i*mul+add); a full 512-byte sector is committed to the
    // model only if a half was free when it started.
    task automatic send_bytes(input int n, input int mul, input int add);
        logic [15:0] pend[$];
        logic [7:0]  lo;
        logic [7:0]  b;
        bit          take;
        lo   = 8'h00;
        take = play_en && (model_halves() < 2);
        for (int i = 0; i < n; i++) begin
            b = 8'((i * mul + add) & 255);
            @(negedge clock_50M);
            byte_valid = 1'b1;
            byte_data  = b;
            if ((i % 2) == 0) lo = b;
            else pend.push_back({b, lo});
        end
        @(negedge clock_50M);
        byte_valid = 1'b0;
        if (take && n == 512) begin
            foreach (pend[k]) model_q.push_back(pend[k]);
        end
    endtask

    task automatic read_sample(input string tag);
        logic [15:0] e;
        if (model_q.size() > 0) e = model_q.pop_front();
        else e = 16'h0000;
        sb_q.push_back(e);
        @(negedge clock_50M);
        sample_req = 1'b1;
        @(negedge clock_50M);
        sample_req = 1'b0;
        check_val({tag, "_hold"}, 32'(wav_data), 32'(last_wav));
        @(negedge clock_50M);
        e = sb_q.pop_front();
        check_val(tag, 32'(wav_data), 32'(e));
        last_wav = e;
    endtask

    initial begin
        rst_n      = 1'b0;
        play_en    = 1'b0;
        byte_data  = 8'h00;
        byte_valid = 1'b0;
        sample_req = 1'b0;
        last_wav   = 16'h0000;

        // 1: reset state, then enable
        wait_cycles(3);
        check_val("rst_sector_req", 32'(sector_req), 32'd0);
        check_val("rst_wav",        32'(wav_data),   32'd0);
        check_val("rst_level",      32'(buf_level),  32'd0);
        check_val("rst_underrun",   32'(underrun),   32'd0);
        check_val("rst_overflow",   32'(overflow),   32'd0);
        rst_n = 1'b1;
        wait_cycles(2);
        play_en = 1'b1;
        @(negedge clock_50M);
        check_val("en_sector_req", 32'(sector_req), 32'd1);
        check_val("en_level",      32'(buf_level),  32'd0);

        // 2: one sector, first two samples
        send_bytes(512, 1, 0);
        wait_cycles(2);
        check_val("s1_level",      32'(buf_level),  32'd1);
        check_val("s1_sector_req", 32'(sector_req), 32'd1);
        read_sample("s1_first");
        read_sample("s1_second");

        // 3: both halves full, drain half 0, wrap to half 1
        send_bytes(512, 3, 7);
        wait_cycles(2);
        check_val("s2_level",      32'(buf_level),  32'd2);
        check_val("s2_sector_req", 32'(sector_req), 32'd0);
        for (int i = 0; i < 254; i++) read_sample("drain0");
        wait_cycles(1);
        check_val("d0_level",      32'(buf_level),  32'd1);
        check_val("d0_sector_req", 32'(sector_req), 32'd1);
        for (int i = 0; i < 256; i++) read_sample("drain1");
        wait_cycles(1);
        check_val("d1_level", 32'(buf_level), 32'd0);

        // 4: underrun
        check_val("pre_underrun", 32'(underrun), 32'd0);
        read_sample("starved");
        check_val("underrun_set", 32'(underrun), 32'd1);
        wait_cycles(5);
        check_val("underrun_sticky", 32'(underrun), 32'd1);

        // 5: overflow with both halves full, contents unchanged
        send_bytes(512, 5, 3);
        send_bytes(512, 7, 11);
        wait_cycles(2);
        check_val("ov_level_pre", 32'(buf_level), 32'd2);
        check_val("ov_pre",       32'(overflow),  32'd0);
        send_bytes(10, 1, 200);
        wait_cycles(1);
        check_val("ov_set",        32'(overflow),  32'd1);
        check_val("ov_level_post", 32'(buf_level), 32'd2);
        for (int i = 0; i < 512; i++) read_sample("ov_data");

        // 6: stop mid-sector, then restart
        send_bytes(512, 1, 50);
        read_sample("pre_stop");
        send_bytes(101, 1, 0);
        @(negedge clock_50M);
        play_en = 1'b0;
        @(negedge clock_50M);
        check_val("stop_level",      32'(buf_level),  32'd0);
        check_val("stop_wav",        32'(wav_data),   32'd0);
        check_val("stop_sector_req", 32'(sector_req), 32'd0);
        check_val("stop_underrun",   32'(underrun),   32'd1);
        check_val("stop_overflow",   32'(overflow),   32'd1);
        model_q.delete();
        last_wav = 16'h0000;
        wait_cycles(3);
        play_en = 1'b1;
        @(negedge clock_50M);
        check_val("re_sector_req", 32'(sector_req), 32'd1);
        check_val("re_underrun",   32'(underrun),   32'd0);
        check_val("re_overflow",   32'(overflow),   32'd0);
        check_val("re_level",      32'(buf_level),  32'd0);
        send_bytes(512, 1, 0);
        wait_cycles(2);
        check_val("re_level_full", 32'(buf_level), 32'd1);
        read_sample("re_first");
        read_sample("re_second");
        read_sample("re_third");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
